md5_result_collector: RTL and testbench
=======================================

// Module: md5_result_collector
//
// PURPOSE
// - Downstream of the md5calculator array: gathers one 128-bit digest per core when its done rises.
// - Serialises the digests into a single valid/ready stream tagged with the core index.
// - Raises all_done once every core has been collected and the stream has drained.
// - Replaces per-core $display polling with a single synthesizable reporting point.
//
// PARAMETERS
// - CPU_COUNT   16  number of md5calculator cores observed; must be >= 2
// - FIFO_DEPTH  8   result FIFO entries; power of two, >= 2
// - ID_W        $clog2(CPU_COUNT)  derived localparam, width of the core index
//
// PORTS
// - clock         in   1              system clock
// - reset         in   1              synchronous, active-high
// - cpu_done      in   CPU_COUNT      level per core, high while its digest is valid
// - cpu_md5       in   CPU_COUNT*128  flattened digests, core n at [n*128 +: 128]
// - out_valid     out  1              result available
// - out_ready     in   1              sink accepts the result
// - out_id        out  ID_W           core index of the presented result
// - out_md5       out  128            digest of the presented result
// - collected     out  CPU_COUNT      bitmap of cores already captured
// - done_count    out  ID_W+1         number of results popped so far
// - all_done      out  1              every core captured and every result popped
//
// BEHAVIOUR
// - Reset (clock edge with reset=1): collected=0, rr_ptr=0, FIFO empty, out_valid=0,
//   out_id=0, out_md5=0, done_count=0, all_done=0. Reset mid-operation discards the
//   FIFO contents and the bitmap; cores still high are recaptured after reset drops.
// - Request vector req = cpu_done & ~collected. Round-robin arbiter: grant the lowest
//   index >= rr_ptr with req set, wrapping to 0. At most one grant per cycle.
// - A capture happens on the edge where req!=0 and the FIFO is not full (registered full flag).
//   The edge pushes {id,md5}, sets collected[id], and sets rr_ptr = id+1 (wraps to 0 after CPU_COUNT-1).
// - FIFO full: no grant; req stays pending and rr_ptr is held. cpu_done is sampled at
//   capture time only. If done falls before capture, nothing is recorded.
// - Latency: done high at edge t (FIFO empty) -> out_valid=1 after edge t+1.
//   The FIFO has a registered output and no combinational fall-through.
// - Pop on out_valid & out_ready. out_id/out_md5 are held stable while out_valid & !out_ready.
// - Simultaneous push and pop are legal at any occupancy below full. At full, the pop frees
//   the slot, but the push waits one cycle because full is registered.
// - done_count is incremented per pop. It saturates at CPU_COUNT and never wraps.
// - all_done is registered. It goes to 1 on the edge after collected is all ones, the FIFO is
//   empty and no pop is pending. It then stays 1 until reset.
// - A core whose done falls after capture is ignored. Re-assertion is not recaptured.
//
// STRUCTURE
// - Package md5_bench_pkg: typedef logic [127:0] md5_t;
//   typedef struct packed {logic [ID_W-1:0] id; md5_t md5;} md5_result_t,
//   shared with the testbench.
// - Sub-module md5_result_fifo: synchronous FIFO of md5_result_t (DEPTH param) with
//   registered full/empty and registered output stage.
// - Arbiter, bitmap, counters and all_done logic live in md5_result_collector itself.
//
// TESTING
// - Single core: CPU_COUNT=4, only core 2 done, md5=128'h0123..cdef, out_ready=1
//   -> one beat, out_id=2, exact md5 value, all_done stays 0.
// - All cores done in the same cycle, out_ready=1 -> ids popped in order 0,1,2,3.
//   done_count=4, and all_done=1 exactly one cycle after the last pop.
// - Backpressure: CPU_COUNT=16, FIFO_DEPTH=4, all done, out_ready=0 for 20 cycles.
//   -> exactly 4 captures, out_id/out_md5 stable, then ready=1 drains ids 0..15 with no loss or duplication.
// - Round-robin fairness: core 3 captured, then cores 1 and 5 rise together.
//   -> core 5 granted first (rr_ptr=4), then core 1.
// - Done pulse dropped: core 1 high for 1 cycle while the FIFO is full -> never captured,
//   collected[1]=0, all_done never asserts.
// - Reset mid-run after 2 of 4 pops -> outputs zero next cycle, and all 4 cores are
//   recaptured and popped again with done_count reaching 4.

Source files
------------

// File: rtl/md5_bench_pkg.sv
// Shared types for the md5 result collector and its bench.
// md5_result_t is sized for the default 16-core array; the collector re-derives it per instance.
package md5_bench_pkg;

  typedef logic [127:0] md5_t;

  localparam int DEFAULT_CPU_COUNT = 16;
  localparam int DEFAULT_ID_W      = $clog2(DEFAULT_CPU_COUNT);

  typedef struct packed {
    logic [DEFAULT_ID_W-1:0] id;
    md5_t                    md5;
  } md5_result_t;

endpackage

// File: rtl/md5_result_fifo.sv
// Synchronous result FIFO with registered full/empty and a registered head stage.
// The head is always an entry already stored, so a push never falls through in the same cycle.
module md5_result_fifo
  import md5_bench_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = md5_result_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output logic   out_valid,
  output entry_t out_data
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] load_addr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;
  logic          load;

  // count includes the entry sitting in the head register until it is popped
  always_comb begin
    push_ok    = push & ~full;
    pop_ok     = pop & out_valid;
    rd_next    = rd_ptr + 1'b1;
    load       = out_valid ? (pop_ok && count >= (PW+1)'(2)) : (count != '0);
    load_addr  = out_valid ? rd_next : rd_ptr;
    count_next = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      count <= count_next;
      full  <= (count_next == (PW+1)'(DEPTH));
      empty <= (count_next == '0);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mem[load_addr];
      end else if (pop_ok) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/md5_result_collector.sv
// Collects one digest per md5calculator core and serialises them into a tagged
// valid/ready stream, raising all_done once every core is reported and drained.
module md5_result_collector
  import md5_bench_pkg::*;
#(
  parameter  int CPU_COUNT  = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int ID_W       = $clog2(CPU_COUNT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CPU_COUNT-1:0]     cpu_done,
  input  logic [CPU_COUNT*128-1:0] cpu_md5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic [127:0]             out_md5,
  output logic [CPU_COUNT-1:0]     collected,
  output logic [ID_W:0]            done_count,
  output logic                     all_done
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    md5_t            md5;
  } entry_t;

  logic [CPU_COUNT-1:0] req;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  entry_t               push_data;
  entry_t               head;
  int                   idx;

  // Round-robin search starting at rr_ptr; the first requester found wins
  always_comb begin
    req         = cpu_done & ~collected;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CPU_COUNT) idx = idx - CPU_COUNT;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    push           = grant_valid & ~fifo_full;
    pop            = out_valid & out_ready;
    push_data.id   = grant_id;
    push_data.md5  = cpu_md5[grant_id*128 +: 128];
  end

  md5_result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .out_valid (out_valid),
    .out_data  (head)
  );

  assign out_id  = head.id;
  assign out_md5 = head.md5;

  always_ff @(posedge clock) begin
    if (reset) begin
      collected  <= '0;
      rr_ptr     <= '0;
      done_count <= '0;
      all_done   <= 1'b0;
    end else begin
      if (push) begin
        collected[grant_id] <= 1'b1;
        rr_ptr <= (grant_id == ID_W'(CPU_COUNT - 1)) ? '0 : grant_id + 1'b1;
      end
      if (pop && done_count < (ID_W+1)'(CPU_COUNT)) done_count <= done_count + 1'b1;
      if (&collected && fifo_empty && !pop) all_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md5_result_collector.sv
// Directed bench: a 4-core/8-deep collector and a 16-core/4-deep collector share one clock.
module tb_md5_result_collector;
  import md5_bench_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]   a_done;
  logic [511:0] a_md5;
  logic         a_valid, a_ready, a_all;
  logic [1:0]   a_id;
  logic [127:0] a_out_md5;
  logic [3:0]   a_collected;
  logic [2:0]   a_count;

  logic [15:0]   b_done;
  logic [2047:0] b_md5;
  logic          b_valid, b_ready, b_all;
  logic [3:0]    b_id;
  logic [127:0]  b_out_md5;
  logic [15:0]   b_collected;
  logic [4:0]    b_count;

  int vectors = 0;
  int miscompares = 0;
  int got[$];

  md5_result_collector #(.CPU_COUNT(4), .FIFO_DEPTH(8)) dut_a (
    .clock(clock), .reset(reset), .cpu_done(a_done), .cpu_md5(a_md5),
    .out_valid(a_valid), .out_ready(a_ready), .out_id(a_id), .out_md5(a_out_md5),
    .collected(a_collected), .done_count(a_count), .all_done(a_all)
  );

  md5_result_collector #(.CPU_COUNT(16), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .cpu_done(b_done), .cpu_md5(b_md5),
    .out_valid(b_valid), .out_ready(b_ready), .out_id(b_id), .out_md5(b_out_md5),
    .collected(b_collected), .done_count(b_count), .all_done(b_all)
  );

  function automatic md5_t md5_of(input int n);
    logic [31:0] w;
    w = 32'h9E3779B9 ^ 32'(n);
    return {w, ~w, w, ~w};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_done = '0; a_ready = 1'b0; b_done = '0; b_ready = 1'b0;
    for (int n = 0; n < 4; n++)  a_md5[n*128 +: 128] = md5_of(n);
    for (int n = 0; n < 16; n++) b_md5[n*128 +: 128] = md5_of(n);
    step();
    reset = 1'b0;
  endtask

  task automatic drain_a(input int n, input int budget);
    got.delete();
    for (int c = 0; c < budget && got.size() < n; c++) begin
      if (a_valid && a_ready) begin
        got.push_back(int'(a_id));
        vectors++;
        if (a_out_md5 !== md5_of(int'(a_id))) begin
          miscompares++;
          $display("[TB] FAIL a_md5 id=%0d got %h want %h", a_id, a_out_md5, md5_of(int'(a_id)));
        end
      end
      step();
    end
    vectors++;
    if (got.size() != n) begin
      miscompares++;
      $display("[TB] FAIL a_drain_timeout got %0d beats want %0d", got.size(), n);
    end
  endtask

  task automatic drain_b(input int n, input int budget);
    got.delete();
    for (int c = 0; c < budget && got.size() < n; c++) begin
      if (b_valid && b_ready) begin
        got.push_back(int'(b_id));
        vectors++;
        if (b_out_md5 !== md5_of(int'(b_id))) begin
          miscompares++;
          $display("[TB] FAIL b_md5 id=%0d got %h want %h", b_id, b_out_md5, md5_of(int'(b_id)));
        end
      end
      step();
    end
    vectors++;
    if (got.size() != n) begin
      miscompares++;
      $display("[TB] FAIL b_drain_timeout got %0d beats want %0d", got.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_done = '0; a_ready = 1'b0; b_done = '0; b_ready = 1'b0;
    a_md5 = '0; b_md5 = '0;
    step();
    vectors += 6;
    if (a_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_a_valid got %b want 0", a_valid); end
    if (a_id !== 2'd0)      begin miscompares++; $display("[TB] FAIL reset_a_id got %0d want 0", a_id); end
    if (a_out_md5 !== '0)   begin miscompares++; $display("[TB] FAIL reset_a_md5 got %h want 0", a_out_md5); end
    if (a_collected !== '0) begin miscompares++; $display("[TB] FAIL reset_a_collected got %b want 0", a_collected); end
    if (a_count !== '0)     begin miscompares++; $display("[TB] FAIL reset_a_count got %0d want 0", a_count); end
    if (b_all !== 1'b0 || b_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_b got all=%b valid=%b want 0 0", b_all, b_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_core();
    md5_t v;
    v = 128'h0123456789abcdef0123456789abcdef;
    do_reset();
    a_done = 4'b0100;
    a_md5[2*128 +: 128] = v;
    a_ready = 1'b1;
    step();
    vectors++;
    if (a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_latency_early got valid=%b want 0", a_valid); end
    step();
    vectors += 4;
    if (a_valid !== 1'b1)      begin miscompares++; $display("[TB] FAIL single_valid got %b want 1", a_valid); end
    if (a_id !== 2'd2)         begin miscompares++; $display("[TB] FAIL single_id got %0d want 2", a_id); end
    if (a_out_md5 !== v)       begin miscompares++; $display("[TB] FAIL single_md5 got %h want %h", a_out_md5, v); end
    if (a_collected !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_collected got %b want 0100", a_collected); end
    step();
    vectors += 2;
    if (a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_after_pop got valid=%b want 0", a_valid); end
    if (a_count !== 3'd1) begin miscompares++; $display("[TB] FAIL single_count got %0d want 1", a_count); end
    for (int c = 0; c < 5; c++) step();
    vectors++;
    if (a_all !== 1'b0) begin miscompares++; $display("[TB] FAIL single_all_done got %b want 0", a_all); end
  endtask

  task automatic test_all_same_cycle();
    do_reset();
    a_done = 4'hF;
    a_ready = 1'b1;
    drain_a(4, 40);
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] != i) begin miscompares++; $display("[TB] FAIL all_order beat %0d got id %0d want %0d", i, got[i], i); end
    end
    vectors += 2;
    if (a_all !== 1'b0)   begin miscompares++; $display("[TB] FAIL all_done_early got %b want 0", a_all); end
    if (a_count !== 3'd4) begin miscompares++; $display("[TB] FAIL all_count got %0d want 4", a_count); end
    step();
    vectors++;
    if (a_all !== 1'b1) begin miscompares++; $display("[TB] FAIL all_done_late got %b want 1", a_all); end
  endtask

  task automatic test_backpressure();
    do_reset();
    b_done = 16'hFFFF;
    b_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (b_valid) begin
        vectors++;
        if (b_id !== 4'd0 || b_out_md5 !== md5_of(0)) begin
          miscompares++;
          $display("[TB] FAIL bp_stable cycle %0d got id %0d md5 %h want id 0 md5 %h", c, b_id, b_out_md5, md5_of(0));
        end
      end
    end
    vectors += 2;
    if (b_valid !== 1'b1)       begin miscompares++; $display("[TB] FAIL bp_valid got %b want 1", b_valid); end
    if (b_collected !== 16'h000F) begin miscompares++; $display("[TB] FAIL bp_captures got %h want 000f", b_collected); end
    b_ready = 1'b1;
    drain_b(16, 200);
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] != i) begin miscompares++; $display("[TB] FAIL bp_order beat %0d got id %0d want %0d", i, got[i], i); end
    end
    vectors++;
    if (b_count !== 5'd16) begin miscompares++; $display("[TB] FAIL bp_count got %0d want 16", b_count); end
    step();
    vectors++;
    if (b_all !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_all_done got %b want 1", b_all); end
  endtask

  task automatic test_round_robin();
    int exp_ids[3];
    exp_ids = '{3, 5, 1};
    do_reset();
    b_done = 16'h0008;
    b_ready = 1'b1;
    step();
    b_done = 16'h002A;
    drain_b(3, 40);
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] != exp_ids[i]) begin
        miscompares++; $display("[TB] FAIL rr_order beat %0d got id %0d want %0d", i, got[i], exp_ids[i]);
      end
    end
  endtask

  task automatic test_dropped_pulse();
    int exp_ids[4];
    exp_ids = '{0, 2, 3, 4};
    do_reset();
    b_done = 16'h001D;
    b_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    b_done = 16'h001F;
    step();
    b_done = 16'h001D;
    vectors++;
    if (b_collected !== 16'h001D) begin miscompares++; $display("[TB] FAIL drop_collected got %h want 001d", b_collected); end
    b_ready = 1'b1;
    drain_b(4, 40);
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] != exp_ids[i]) begin
        miscompares++; $display("[TB] FAIL drop_order beat %0d got id %0d want %0d", i, got[i], exp_ids[i]);
      end
    end
    for (int c = 0; c < 5; c++) step();
    vectors += 3;
    if (b_collected[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_core1 got %b want 0", b_collected[1]); end
    if (b_all !== 1'b0)          begin miscompares++; $display("[TB] FAIL drop_all_done got %b want 0", b_all); end
    if (b_count !== 5'd4)        begin miscompares++; $display("[TB] FAIL drop_count got %0d want 4", b_count); end
  endtask

  task automatic test_mid_run_reset();
    do_reset();
    a_done = 4'hF;
    a_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    a_ready = 1'b1;
    drain_a(2, 10);
    a_ready = 1'b0;
    vectors++;
    if (a_count !== 3'd2) begin miscompares++; $display("[TB] FAIL mid_count_before got %0d want 2", a_count); end
    reset = 1'b1;
    step();
    vectors++;
    if (a_valid !== 1'b0 || a_id !== 2'd0 || a_out_md5 !== '0 || a_collected !== '0 || a_count !== '0 || a_all !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got valid=%b id=%0d md5=%h coll=%b cnt=%0d all=%b want all zero",
               a_valid, a_id, a_out_md5, a_collected, a_count, a_all);
    end
    reset = 1'b0;
    a_ready = 1'b1;
    drain_a(4, 40);
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] != i) begin miscompares++; $display("[TB] FAIL mid_order beat %0d got id %0d want %0d", i, got[i], i); end
    end
    vectors++;
    if (a_count !== 3'd4) begin miscompares++; $display("[TB] FAIL mid_count_after got %0d want 4", a_count); end
    step();
    vectors++;
    if (a_all !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_all_done got %b want 1", a_all); end
  endtask

  initial begin
    a_done = '0; a_md5 = '0; a_ready = 1'b0;
    b_done = '0; b_md5 = '0; b_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_core();
    test_all_same_cycle();
    test_backpressure();
    test_round_robin();
    test_dropped_pulse();
    test_mid_run_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
